lsu: RTL and testbench

Load-store unit for the single-cycle RV32I core: consumes the memory controls produced by the instruction decoder (load/store width code, memory write enable) together with the ALU-computed address and rs2 store data. It owns the data memory and the memory-mapped I/O registers. It returns sign- or zero-extended load data to the writeback mux. Placement: between the ALU result and the writeback select.

---
 rtl/lsu.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load-store unit for the single-cycle RV32I core. Owns the data
//            memory and the memory-mapped I/O registers. Loads are
//            combinational and return sign- or zero-extended data. Stores
//            commit on the rising clock edge with per-byte-lane masking.
// Ports    : clk_i, rst_ni          clock, synchronous active-low reset
//            addr_i, st_data_i      ALU byte address, rs2 store data
//            st_en_i, loadsave_op_i store enable, funct3 width code
//            ld_data_o              extended load data (combinational)
//            misaligned_o           current access is misaligned
//            io_sw_i, io_btn_i      asynchronous board inputs
//            io_ledr_o .. io_lcd_o  writable I/O register outputs
// Config   : LSU_IO_SYNC_EN - when defined, switches/buttons pass through a
//            two-flop synchronizer (2-edge latency); otherwise through a
//            single sampling register (1-edge latency).
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int          DMEM_ADDR_W = 13,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
    parameter logic [31:0] IO_BASE     = 32'h0000_7000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic        st_en_i,
    input  logic [2:0]  loadsave_op_i,
    output logic [31:0] ld_data_o,
    output logic        misaligned_o,
    input  logic [31:0] io_sw_i,
    input  logic [3:0]  io_btn_i,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_ledg_o,
    output logic [31:0] io_hexl_o,
    output logic [31:0] io_hexh_o,
    output logic [31:0] io_lcd_o
);

    localparam int          c_depth     = 2 ** (DMEM_ADDR_W - 2);
    localparam logic [31:0] c_ledr_addr = IO_BASE + 32'h0000_0000;
    localparam logic [31:0] c_ledg_addr = IO_BASE + 32'h0000_0010;
    localparam logic [31:0] c_hexl_addr = IO_BASE + 32'h0000_0020;
    localparam logic [31:0] c_hexh_addr = IO_BASE + 32'h0000_0024;
    localparam logic [31:0] c_lcd_addr  = IO_BASE + 32'h0000_0030;
    localparam logic [31:0] c_sw_addr   = IO_BASE + 32'h0000_0800;
    localparam logic [31:0] c_btn_addr  = IO_BASE + 32'h0000_0810;

    logic [31:0] r_mem [c_depth];
    logic [31:0] r_ledr, r_ledg, r_hexl, r_hexh, r_lcd;
    logic [31:0] r_sw_smp;
    logic [3:0]  r_btn_smp;

    logic [31:0]            w_off;
    logic                   w_in_dmem;
    logic [DMEM_ADDR_W-3:0] w_idx;
    logic [31:0]            w_word_addr;
    logic                   w_sel_ledr, w_sel_ledg, w_sel_hexl, w_sel_hexh, w_sel_lcd;
    logic [31:0]            w_rword;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic                   w_misaligned;
    logic [3:0]             w_mask;
    logic [31:0]            w_wdata;
    logic                   w_store;

    // Offset subtraction makes the range check independent of base alignment:
    // addresses below the base wrap to large values and fail the test.
    assign w_off       = addr_i - DMEM_BASE;
    assign w_in_dmem   = (w_off[31:DMEM_ADDR_W] == '0);
    assign w_idx       = w_off[DMEM_ADDR_W-1:2];
    assign w_word_addr = {addr_i[31:2], 2'b00};

    assign w_sel_ledr = (w_word_addr == c_ledr_addr);
    assign w_sel_ledg = (w_word_addr == c_ledg_addr);
    assign w_sel_hexl = (w_word_addr == c_hexl_addr);
    assign w_sel_hexh = (w_word_addr == c_hexh_addr);
    assign w_sel_lcd  = (w_word_addr == c_lcd_addr);

    // Half accesses are LH/LHU/SH (funct3[1:0]=01); word accesses are LW/SW.
    always_comb begin
        w_misaligned = 1'b0;
        if ((loadsave_op_i[1:0] == 2'b01) && addr_i[0]) begin
            w_misaligned = 1'b1;
        end
        if ((loadsave_op_i == 3'b010) && (addr_i[1:0] != 2'b00)) begin
            w_misaligned = 1'b1;
        end
    end

    // Aligned read word for the addressed location.
    always_comb begin
        w_rword = '0;
        if (w_in_dmem) begin
            w_rword = r_mem[w_idx];
        end else if (w_sel_ledr) begin
            w_rword = r_ledr;
        end else if (w_sel_ledg) begin
            w_rword = r_ledg;
        end else if (w_sel_hexl) begin
            w_rword = r_hexl;
        end else if (w_sel_hexh) begin
            w_rword = r_hexh;
        end else if (w_sel_lcd) begin
            w_rword = r_lcd;
        end else if (w_word_addr == c_sw_addr) begin
            w_rword = r_sw_smp;
        end else if (w_word_addr == c_btn_addr) begin
            w_rword = {28'd0, r_btn_smp};
        end
    end

    assign w_byte = w_rword[8*addr_i[1:0] +: 8];
    assign w_half = addr_i[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        ld_data_o = '0;
        if (!w_misaligned) begin
            case (loadsave_op_i)
                3'b000:  ld_data_o = {{24{w_byte[7]}}, w_byte};
                3'b001:  ld_data_o = {{16{w_half[15]}}, w_half};
                3'b010:  ld_data_o = w_rword;
                3'b100:  ld_data_o = {24'd0, w_byte};
                3'b101:  ld_data_o = {16'd0, w_half};
                default: ld_data_o = '0;
            endcase
        end
    end

    assign misaligned_o = w_misaligned;

    // Store data is replicated across lanes so the mask alone selects bytes.
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = st_data_i;
        case (loadsave_op_i)
            3'b000: begin
                w_mask  = 4'b0001 << addr_i[1:0];
                w_wdata = {4{st_data_i[7:0]}};
            end
            3'b001: begin
                w_mask  = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data_i[15:0]}};
            end
            3'b010: begin
                w_mask  = 4'b1111;
                w_wdata = st_data_i;
            end
            default: begin
                w_mask  = 4'b0000;
                w_wdata = st_data_i;
            end
        endcase
    end

    // Reset wins over any store presented in the same cycle.
    assign w_store = st_en_i && !w_misaligned && rst_ni;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) begin
                res[8*l +: 8] = new_v[8*l +: 8];
            end
        end
        return res;
    endfunction

    // Data memory is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_store && w_in_dmem) begin
            for (int l = 0; l < 4; l++) begin
                if (w_mask[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ledr <= '0;
            r_ledg <= '0;
            r_hexl <= '0;
            r_hexh <= '0;
            r_lcd  <= '0;
        end else if (w_store) begin
            if (w_sel_ledr) r_ledr <= f_merge(r_ledr, w_wdata, w_mask);
            if (w_sel_ledg) r_ledg <= f_merge(r_ledg, w_wdata, w_mask);
            if (w_sel_hexl) r_hexl <= f_merge(r_hexl, w_wdata, w_mask);
            if (w_sel_hexh) r_hexh <= f_merge(r_hexh, w_wdata, w_mask);
            if (w_sel_lcd)  r_lcd  <= f_merge(r_lcd,  w_wdata, w_mask);
        end
    end

    assign io_ledr_o = r_ledr;
    assign io_ledg_o = r_ledg;
    assign io_hexl_o = r_hexl;
    assign io_hexh_o = r_hexh;
    assign io_lcd_o  = r_lcd;

`ifdef LSU_IO_SYNC_EN
    logic [31:0] r_sw_meta;
    logic [3:0]  r_btn_meta;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sw_meta  <= '0;
            r_btn_meta <= '0;
            r_sw_smp   <= '0;
            r_btn_smp  <= '0;
        end else begin
            r_sw_meta  <= io_sw_i;
            r_btn_meta <= io_btn_i;
            r_sw_smp   <= r_sw_meta;
            r_btn_smp  <= r_btn_meta;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sw_smp  <= '0;
            r_btn_smp <= '0;
        end else begin
            r_sw_smp  <= io_sw_i;
            r_btn_smp <= io_btn_i;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Scoreboard testbench for lsu. A byte-addressed reference model
//            predicts load data, misalignment and I/O register outputs each
//            cycle; a monitor compares them against the DUT at the falling
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        st_en;
    logic [2:0]  op;
    logic [31:0] ld_data;
    logic        misaligned;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [31:0] ledr, ledg, hexl, hexh, lcd;

    lsu dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .addr_i        (addr),
        .st_data_i     (st_data),
        .st_en_i       (st_en),
        .loadsave_op_i (op),
        .ld_data_o     (ld_data),
        .misaligned_o  (misaligned),
        .io_sw_i       (sw),
        .io_btn_i      (btn),
        .io_ledr_o     (ledr),
        .io_ledg_o     (ledg),
        .io_hexl_o     (hexl),
        .io_hexh_o     (hexh),
        .io_lcd_o      (lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LSU_IO_SYNC_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 1;
`endif

    // ---------------- reference model ----------------
    bit [7:0]    mb [int unsigned];
    logic [31:0] sw_pipe  [2];
    logic [3:0]  btn_pipe [2];
    logic [31:0] c_ioregs [5] = '{32'h7000, 32'h7010, 32'h7020, 32'h7024, 32'h7030};

    function automatic bit is_dmem(input logic [31:0] a);
        return (a >= 32'h2000) && (a < 32'h4000);
    endfunction

    function automatic bit is_ioreg(input logic [31:0] a);
        for (int i = 0; i < 5; i++) if ((a & ~32'h3) == c_ioregs[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (is_dmem(a) || is_ioreg(a)) return mb.exists(a) ? mb[a] : 8'h00;
        if (w == 32'h7800) return 8'(sw_pipe[c_lat-1] >> (8 * (a & 3)));
        if (w == 32'h7810) return ((a & 3) == 0) ? {4'h0, btn_pipe[c_lat-1]} : 8'h00;
        return 8'h00;
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [2:0] o);
        if ((o == 3'd1 || o == 3'd5) && a[0]) return 1'b1;
        if (o == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        if (m_mis(a, o)) return 32'h0;
        b = rd_byte(a);
        h = {rd_byte(a + 1), rd_byte(a)};
        case (o)
            3'd0: return 32'($signed(b));
            3'd1: return 32'($signed(h));
            3'd2: return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
            3'd4: return {24'h0, b};
            3'd5: return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] base);
        return {rd_byte(base + 3), rd_byte(base + 2), rd_byte(base + 1), rd_byte(base)};
    endfunction

    // Applies the effect of one rising edge given the inputs held across it.
    task automatic model_edge();
        int n;
        if (!rst_n) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 4; j++) mb.delete(c_ioregs[i] + j);
            sw_pipe  = '{32'h0, 32'h0};
            btn_pipe = '{4'h0, 4'h0};
        end else begin
            if (st_en && !m_mis(addr, op) && op <= 3'd2) begin
                n = 1 << op;
                for (int i = 0; i < n; i++) begin
                    if (is_dmem(addr + i) || is_ioreg(addr + i))
                        mb[addr + i] = 8'(st_data >> (8 * i));
                end
            end
            sw_pipe[1]  = sw_pipe[0];
            sw_pipe[0]  = sw;
            btn_pipe[1] = btn_pipe[0];
            btn_pipe[0] = btn;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [31:0] ld;
        logic        mis;
        logic [31:0] ledr, ledg, hexl, hexh, lcd;
        bit          c_ld_en;
        logic [31:0] c_ld;
        bit          c_mis_en;
        logic        c_mis;
        bit          c_ledr_en;
        logic [31:0] c_ledr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Optional literal expectations attached to the next issued step.
    bit          ce_ld_en,   ce_mis_en,  ce_ledr_en;
    logic [31:0] ce_ld,      ce_ledr;
    logic        ce_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, " ld_data"},  ld_data,           e.ld);
                chk({e.name, " misalign"}, {31'h0, misaligned}, {31'h0, e.mis});
                chk({e.name, " ledr"},     ledr,              e.ledr);
                chk({e.name, " ledg"},     ledg,              e.ledg);
                chk({e.name, " hexl"},     hexl,              e.hexl);
                chk({e.name, " hexh"},     hexh,              e.hexh);
                chk({e.name, " lcd"},      lcd,               e.lcd);
                if (e.c_ld_en)   chk({e.name, " ld_const"},   ld_data, e.c_ld);
                if (e.c_mis_en)  chk({e.name, " mis_const"},  {31'h0, misaligned}, {31'h0, e.c_mis});
                if (e.c_ledr_en) chk({e.name, " ledr_const"}, ledr, e.c_ledr);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic s, input logic [2:0] o, input logic r);
        exp_t e;
        addr = a; st_data = d; st_en = s; op = o; rst_n = r;
        e.name = nm;
        e.ld   = m_load(a, o);
        e.mis  = m_mis(a, o);
        e.ledr = m_reg(32'h7000);
        e.ledg = m_reg(32'h7010);
        e.hexl = m_reg(32'h7020);
        e.hexh = m_reg(32'h7024);
        e.lcd  = m_reg(32'h7030);
        e.c_ld_en = ce_ld_en;     e.c_ld = ce_ld;
        e.c_mis_en = ce_mis_en;   e.c_mis = ce_mis;
        e.c_ledr_en = ce_ledr_en; e.c_ledr = ce_ledr;
        ce_ld_en = 0; ce_mis_en = 0; ce_ledr_en = 0;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic expect_ld(input logic [31:0] v);
        ce_ld_en = 1; ce_ld = v;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: base = 32'h2000 + 4 * $urandom_range(0, 15);
            4:          base = 32'h3FF0 + 4 * $urandom_range(0, 3);
            5, 6:       base = c_ioregs[$urandom_range(0, 4)];
            7:          base = ($urandom_range(0, 1) == 1) ? 32'h7800 : 32'h7810;
            default: begin
                case ($urandom_range(0, 4))
                    0: base = 32'h5000;
                    1: base = 32'h1FFC;
                    2: base = 32'h4000;
                    3: base = 32'h7004;
                    default: base = 32'h7804;
                endcase
            end
        endcase
        return base + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ce_ld_en = 0; ce_mis_en = 0; ce_ledr_en = 0;
        ce_ld = 0; ce_mis = 0; ce_ledr = 0;
        sw = 32'h0; btn = 4'h0;
        addr = 32'h7000; st_data = 32'h0; st_en = 1'b0; op = 3'd2; rst_n = 1'b0;
        sw_pipe = '{32'h0, 32'h0};
        btn_pipe = '{4'h0, 4'h0};
        @(posedge clk);
        model_edge();
        #1;

        // Reset state, including a store dropped because reset wins.
        step("reset0", 32'h7000, 32'hFFFF_FFFF, 1'b1, 3'd2, 1'b0);
        step("reset1", 32'h7810, 32'h0, 1'b0, 3'd2, 1'b0);

        // Give every data-memory word the bench reads a known value.
        for (int i = 0; i < 16; i++)
            step("init", 32'h2000 + 4 * i, $urandom, 1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 4; i++)
            step("init", 32'h3FF0 + 4 * i, $urandom, 1'b1, 3'd2, 1'b1);

        // Sign/zero extension.
        step("sw_deadbeef", 32'h2000, 32'hDEAD_BEEF, 1'b1, 3'd2, 1'b1);
        expect_ld(32'hFFFF_FFDE); step("lb_2003",  32'h2003, 0, 1'b0, 3'd0, 1'b1);
        expect_ld(32'h0000_00DE); step("lbu_2003", 32'h2003, 0, 1'b0, 3'd4, 1'b1);
        expect_ld(32'hFFFF_DEAD); step("lh_2002",  32'h2002, 0, 1'b0, 3'd1, 1'b1);
        expect_ld(32'h0000_BEEF); step("lhu_2000", 32'h2000, 0, 1'b0, 3'd5, 1'b1);

        // Byte merge into an existing word, same-cycle old value.
        step("sw_11223344", 32'h2004, 32'h1122_3344, 1'b1, 3'd2, 1'b1);
        expect_ld(32'h0000_0033);
        step("sb_2005", 32'h2005, 32'h0000_00AA, 1'b1, 3'd4, 1'b1);
        step("sb_2005b", 32'h2005, 32'h0000_00AA, 1'b1, 3'd0, 1'b1);
        expect_ld(32'h1122_AA44); step("lw_2004", 32'h2004, 0, 1'b0, 3'd2, 1'b1);

        // Misaligned store is suppressed; misaligned load returns 0.
        ce_mis_en = 1; ce_mis = 1'b1;
        step("sh_2001_mis", 32'h2001, 32'h0000_FFFF, 1'b1, 3'd1, 1'b1);
        expect_ld(32'hDEAD_BEEF); step("lw_2000_unch", 32'h2000, 0, 1'b0, 3'd2, 1'b1);
        ce_mis_en = 1; ce_mis = 1'b1; expect_ld(32'h0);
        step("lw_2002_mis", 32'h2002, 0, 1'b0, 3'd2, 1'b1);

        // LED store dropped under reset, then applied.
        step("ledr_st_rst", 32'h7000, 32'h0000_00FF, 1'b1, 3'd2, 1'b0);
        ce_ledr_en = 1; ce_ledr = 32'h0;
        step("ledr_st", 32'h7000, 32'h0000_00FF, 1'b1, 3'd2, 1'b1);
        ce_ledr_en = 1; ce_ledr = 32'h0000_00FF;
        step("ledr_after", 32'h7000, 0, 1'b0, 3'd2, 1'b1);

        // Switch sampling latency.
        step("sw_idle", 32'h7800, 0, 1'b0, 3'd2, 1'b1);
        step("sw_idle2", 32'h7800, 0, 1'b0, 3'd2, 1'b1);
        sw = 32'h0000_05A5;
        expect_ld(32'h0); step("sw_edge0", 32'h7800, 0, 1'b0, 3'd2, 1'b1);
        expect_ld((c_lat == 1) ? 32'h0000_05A5 : 32'h0);
        step("sw_edge1", 32'h7800, 0, 1'b0, 3'd2, 1'b1);
        expect_ld(32'h0000_05A5); step("sw_edge2", 32'h7800, 0, 1'b0, 3'd2, 1'b1);

        // Unmapped accesses.
        expect_ld(32'h0); step("lw_5000", 32'h5000, 0, 1'b0, 3'd2, 1'b1);
        step("sw_5000", 32'h5000, 32'h1234_5678, 1'b1, 3'd2, 1'b1);
        expect_ld(32'hDEAD_BEEF); step("lw_2000_after", 32'h2000, 0, 1'b0, 3'd2, 1'b1);
        expect_ld(32'h0); step("lw_4000", 32'h4000, 0, 1'b0, 3'd2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) sw  = $urandom;
            if ($urandom_range(0, 4) == 0) btn = 4'($urandom);
            step("rand", rand_addr(), $urandom, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 29) != 0));
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
